// File: rtl/secuenciador_rtc_pkg.sv
// secuenciador_rtc_pkg: register codes, RTC address table and FSM states shared by the RTC blocks
package secuenciador_rtc_pkg;
    typedef enum logic [1:0] {REPOSO, LANZA, ESPERA, ENTREGA} estado_t;
    localparam logic [3:0] COD_NINGUNO    = 4'd0;
    localparam logic [3:0] COD_SEG        = 4'd1;
    localparam logic [3:0] COD_DIA        = 4'd4;
    localparam logic [3:0] COD_CRONO_SEG  = 4'd7;
    localparam logic [3:0] COD_CRONO_HORA = 4'd9;
    // codes 1..6 map to 0x21..0x26, codes 7..9 to 0x41..0x43
    function automatic logic [7:0] dir_de(input logic [3:0] c);
        return c >= COD_CRONO_SEG ? 8'h3A + {4'h0, c} : c != COD_NINGUNO ? 8'h20 + {4'h0, c} : 8'h00;
    endfunction
    function automatic logic [3:0] cod_ini(input logic [2:0] g);
        return g[0] ? COD_SEG : g[1] ? COD_DIA : COD_CRONO_SEG;
    endfunction
endpackage

// File: rtl/secuenciador_rtc_if.sv
// secuenciador_rtc_if: handshake between the scheduler and the RTC bus interface
interface secuenciador_rtc_if;
    logic       bus_inicio;
    logic       bus_wr;
    logic       bus_listo;
    logic [7:0] bus_dir;
    modport master(output bus_inicio, bus_wr, bus_dir, input bus_listo);
    modport slave(input bus_inicio, bus_wr, bus_dir, output bus_listo);
endinterface

// File: rtl/secuenciador_rtc_arbitro.sv
// arbitro_rr3: 3-way round-robin grant; ptr holds the last granted index
module arbitro_rr3 (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       acepta,
    input  logic [2:0] req,
    input  logic [2:0] mascara,
    output logic [2:0] grant,
    output logic       hay
);
    logic [1:0] ptr, p1, p2;
    logic [2:0] r;
    always_comb begin
        r     = req & ~mascara;
        p1    = ptr == 2'd2 ? 2'd0 : ptr + 2'd1;
        p2    = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
        grant = r[p1] ? 3'b001 << p1 : r[p2] ? 3'b001 << p2 : r[ptr] ? 3'b001 << ptr : 3'b000;
        hay   = |r;
    end
    always_ff @(posedge reloj or negedge resetM)
        if (!resetM) ptr <= 2'd0;
        else if (acepta) ptr <= grant[0] ? 2'd0 : grant[1] ? 2'd1 : 2'd2;
endmodule

// File: rtl/secuenciador_rtc.sv
// secuenciador_rtc: schedules the periodic read sweep and round-robin write-backs on the RTC bus
module secuenciador_rtc
    import secuenciador_rtc_pkg::*;
#(
    parameter int T_ESPERA = 255
) (
    input  logic                      reloj,
    input  logic                      resetM,
    input  logic                      tick_lectura,
    input  logic [2:0]                req_esc,
    secuenciador_rtc_if.master        bus,
    output logic [2:0]                ack_esc,
    output logic [3:0]                Selec_Demux_DD,
    output logic                      READ,
    output logic                      ocupado,
    output logic                      err_bus
);
    estado_t    estado, sig;
    logic       pend_lect, prev_lect, es_lect, exito;
    logic       inicia_lect, inicia_esc, fin_espera, ultimo, hay;
    logic [3:0] cod, cod_fin;
    logic [2:0] conc, mascara, grant;
    logic [7:0] cnt;

    arbitro_rr3 u_arb (
        .reloj  (reloj),
        .resetM (resetM),
        .acepta (inicia_esc),
        .req    (req_esc),
        .mascara(mascara),
        .grant  (grant),
        .hay    (hay)
    );

    // a pending sweep wins right after a write so reads and writes alternate
    always_comb begin
        inicia_lect       = estado == REPOSO && pend_lect && (!prev_lect || !hay);
        inicia_esc        = estado == REPOSO && !inicia_lect && hay;
        fin_espera        = bus.bus_listo || cnt == 8'(T_ESPERA);
        ultimo            = !exito || cod == cod_fin;
        sig               = estado == REPOSO ? ((inicia_lect || inicia_esc) ? LANZA : REPOSO) :
                            estado == LANZA  ? ESPERA :
                            estado == ESPERA ? (fin_espera ? ENTREGA : ESPERA) :
                            (ultimo ? REPOSO : LANZA);
        ocupado           = estado != REPOSO;
        bus.bus_inicio    = estado == LANZA;
        bus.bus_wr        = ocupado && !es_lect;
        bus.bus_dir       = ocupado ? dir_de(cod) : 8'h00;
        Selec_Demux_DD    = ocupado ? cod : COD_NINGUNO;
        READ              = estado == ENTREGA && es_lect && exito;
        ack_esc           = (estado == ENTREGA && !es_lect && ultimo) ? conc : 3'b000;
    end

    always_ff @(posedge reloj or negedge resetM)
        if (!resetM) begin
            estado    <= REPOSO;
            pend_lect <= 1'b0;
            prev_lect <= 1'b0;
            es_lect   <= 1'b0;
            exito     <= 1'b0;
            err_bus   <= 1'b0;
            cod       <= COD_NINGUNO;
            cod_fin   <= COD_NINGUNO;
            conc      <= 3'b000;
            mascara   <= 3'b000;
            cnt       <= 8'd0;
        end else begin
            estado    <= sig;
            pend_lect <= tick_lectura | (pend_lect & ~inicia_lect);
            mascara   <= ack_esc;
            cnt       <= estado == LANZA ? 8'd0 : (estado == ESPERA && cnt != 8'(T_ESPERA)) ? cnt + 8'd1 : cnt;
            if (inicia_lect) begin
                es_lect   <= 1'b1;
                prev_lect <= 1'b1;
                conc      <= 3'b000;
                cod       <= COD_SEG;
                cod_fin   <= COD_CRONO_HORA;
            end else if (inicia_esc) begin
                es_lect   <= 1'b0;
                prev_lect <= 1'b0;
                conc      <= grant;
                cod       <= cod_ini(grant);
                cod_fin   <= cod_ini(grant) + 4'd2;
            end
            if (estado == ENTREGA) cod <= cod + 4'd1;
            // a bus_listo in the saturation cycle still counts as success
            if (estado == ESPERA && fin_espera) begin
                exito   <= bus.bus_listo;
                err_bus <= err_bus | ~bus.bus_listo;
            end
        end
endmodule

// File: tb/tb_secuenciador_rtc.sv
// tb_secuenciador_rtc: randomized rounds checked by a scoreboard fed from a sequence-level model
module tb_secuenciador_rtc;
    logic       reloj = 1'b0, resetM = 1'b0, tick_lectura = 1'b0;
    logic [2:0] req_esc = 3'b000;
    logic [2:0] ack_esc;
    logic [3:0] sel;
    logic       READ, ocupado, err_bus;

    secuenciador_rtc_if bus();

    secuenciador_rtc #(.T_ESPERA(255)) dut (
        .reloj         (reloj),
        .resetM        (resetM),
        .tick_lectura  (tick_lectura),
        .req_esc       (req_esc),
        .bus           (bus),
        .ack_esc       (ack_esc),
        .Selec_Demux_DD(sel),
        .READ          (READ),
        .ocupado       (ocupado),
        .err_bus       (err_bus)
    );

    always #5 reloj = ~reloj;

    typedef struct {
        int         tipo;
        logic [7:0] dir;
        logic       wr;
        logic [3:0] sel;
        logic [2:0] ack;
    } ev_t;

    ev_t        esp[$];
    int         checks = 0, errors = 0;
    bit         retener2 = 0, mudo = 0;
    int         ptr_m = 0;
    bit         prev_lect_m = 0;
    logic [7:0] dirs [1:9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic comparar(input int t, input logic [7:0] d, input logic w, input logic [3:0] s, input logic [2:0] a);
        ev_t e;
        bit ok;
        checks++;
        if (esp.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got tipo=%0d dir=%h wr=%0d sel=%0d ack=%b, expected none", t, d, w, s, a);
        end else begin
            e  = esp.pop_front();
            ok = e.tipo == t && (t == 0 ? (e.dir == d && e.wr == w && e.sel == s) : t == 1 ? e.sel == s : e.ack == a);
            if (!ok) begin
                errors++;
                $display("FAIL event: got tipo=%0d dir=%h wr=%0d sel=%0d ack=%b, expected tipo=%0d dir=%h wr=%0d sel=%0d ack=%b",
                         t, d, w, s, a, e.tipo, e.dir, e.wr, e.sel, e.ack);
            end
        end
    endtask

    // one sequence: registers ini..fin, stopping after the register that times out
    task automatic push_seq(input bit lect, input int k, input int corte);
        int ini = lect ? 1 : 3 * k + 1;
        int fin = lect ? 9 : ini + 2;
        for (int c = ini; c <= fin; c++) begin
            esp.push_back(ev_t'{0, dirs[c], !lect, 4'(c), 3'b000});
            if (c == corte) break;
            if (lect) esp.push_back(ev_t'{1, 8'h00, 1'b0, 4'(c), 3'b000});
        end
        if (!lect) esp.push_back(ev_t'{2, 8'h00, 1'b0, 4'h0, 3'(1 << k)});
    endtask

    task automatic modelo(input bit tick, input logic [2:0] reqs, input bit medio);
        bit         pr = tick;
        logic [2:0] pw = reqs;
        bit         primero = 1;
        int         k;
        while (pr || pw != 0) begin
            if (pr && (!prev_lect_m || pw == 0)) begin
                push_seq(1, 0, retener2 ? 2 : 0);
                pr          = 0;
                prev_lect_m = 1;
            end else begin
                k = 0;
                for (int o = 1; o <= 3; o++) begin
                    k = (ptr_m + o) % 3;
                    if (pw[k]) break;
                end
                push_seq(0, k, 0);
                pw[k]       = 1'b0;
                ptr_m       = k;
                prev_lect_m = 0;
            end
            if (primero && medio) pr = 1;
            primero = 0;
        end
    endtask

    // requesters drop their level once they see their ack
    task automatic ciclo();
        @(negedge reloj);
        if (ack_esc != 3'b000) req_esc &= ~ack_esc;
    endtask

    task automatic esperar_reposo();
        int quieto = 0, n = 0;
        while (quieto < 3 && n < 5000) begin
            ciclo();
            n++;
            quieto = ocupado ? 0 : quieto + 1;
        end
        chk("idle_timeout", 32'(n >= 5000), 32'd0);
    endtask

    task automatic ronda(input bit tick, input logic [2:0] reqs, input bit medio);
        int n = 0;
        modelo(tick, reqs, medio);
        if (tick) begin
            tick_lectura = 1'b1;
            ciclo();
            tick_lectura = 1'b0;
        end
        req_esc = reqs;
        if (medio) begin
            while (!ocupado && n < 20) begin
                ciclo();
                n++;
            end
            repeat (2) ciclo();
            tick_lectura = 1'b1;
            ciclo();
            tick_lectura = 1'b0;
        end
        esperar_reposo();
        chk("queue_drained", 32'(esp.size()), 32'd0);
    endtask

    initial begin
        bus.bus_listo = 1'b0;
        fork
            forever begin
                @(negedge reloj);
                if (resetM) begin
                    if (bus.bus_inicio) comparar(0, bus.bus_dir, bus.bus_wr, sel, ack_esc);
                    if (READ) comparar(1, bus.bus_dir, bus.bus_wr, sel, ack_esc);
                    if (ack_esc != 3'b000) comparar(2, bus.bus_dir, bus.bus_wr, sel, ack_esc);
                end
            end
            forever begin
                @(negedge reloj);
                if (bus.bus_inicio && !mudo && !(retener2 && bus.bus_dir == 8'h22 && !bus.bus_wr)) begin
                    repeat (1 + $urandom_range(0, 3)) @(negedge reloj);
                    bus.bus_listo = 1'b1;
                    @(negedge reloj);
                    bus.bus_listo = 1'b0;
                end
            end
        join_none

        repeat (3) @(negedge reloj);
        chk("rst_ocupado", 32'(ocupado), 32'd0);
        chk("rst_outputs", {20'h0, bus.bus_inicio, bus.bus_wr, READ, err_bus, sel, ack_esc, 1'b0},
            32'd0);
        chk("rst_dir", 32'(bus.bus_dir), 32'd0);
        resetM = 1'b1;
        repeat (2) @(negedge reloj);

        ronda(1, 3'b000, 0);
        ronda(0, 3'b100, 0);
        ronda(0, 3'b111, 0);
        ronda(0, 3'b011, 1);
        ronda(1, 3'b101, 0);
        retener2 = 1;
        ronda(1, 3'b000, 0);
        retener2 = 0;
        chk("err_bus_set", 32'(err_bus), 32'd1);
        for (int i = 0; i < 12; i++) begin
            bit         t = 1'($urandom % 2);
            logic [2:0] r = 3'($urandom % 8);
            if (!t && r == 3'b000) t = 1;
            ronda(t, r, 1'($urandom % 2));
        end
        chk("err_bus_sticky", 32'(err_bus), 32'd1);

        // reset while a crono write waits on the bus
        mudo = 1;
        esp.push_back(ev_t'{0, 8'h41, 1'b1, 4'd7, 3'b000});
        req_esc = 3'b100;
        begin
            int n = 0;
            while (!ocupado && n < 20) begin
                ciclo();
                n++;
            end
        end
        repeat (3) ciclo();
        #2 resetM = 1'b0;
        #1;
        chk("async_rst_ocupado", 32'(ocupado), 32'd0);
        chk("async_rst_outputs", {20'h0, bus.bus_inicio, bus.bus_wr, READ, err_bus, sel, ack_esc, 1'b0}, 32'd0);
        chk("async_rst_dir", 32'(bus.bus_dir), 32'd0);
        req_esc     = 3'b000;
        ptr_m       = 0;
        prev_lect_m = 0;
        repeat (2) @(negedge reloj);
        resetM = 1'b1;
        mudo   = 0;
        repeat (30) ciclo();
        chk("post_rst_idle", 32'(ocupado), 32'd0);
        chk("post_rst_queue", 32'(esp.size()), 32'd0);
        ronda(1, 3'b111, 0);
        chk("final_err_bus", 32'(err_bus), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
